halt_ctrl: RTL and testbench



---
 rtl/halt_ctrl_if.sv | 25 ++
 rtl/halt_ctrl.sv | 108 ++++++++++
 tb/tb_halt_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/halt_ctrl_if.sv
// Commit-side and trap-report signals between the core, halt_ctrl and the exit reporter.
interface halt_ctrl_if;
   logic        commit_valid;
   logic [63:0] commit_pc;
   logic [31:0] commit_inst;
   logic        commit_is_ebreak;
   logic [63:0] a0_value;
   logic        mem_busy;
   logic        halt_req;
   logic        exit;
   logic [63:0] exit_pc;
   logic [31:0] exit_inst;
   logic [63:0] exit_code;
   logic        timeout;

   modport master (
      output commit_valid, commit_pc, commit_inst, commit_is_ebreak, a0_value, mem_busy,
      input  halt_req, exit, exit_pc, exit_inst, exit_code, timeout
   );

   modport slave (
      input  commit_valid, commit_pc, commit_inst, commit_is_ebreak, a0_value, mem_busy,
      output halt_req, exit, exit_pc, exit_inst, exit_code, timeout
   );
endinterface

// File: rtl/halt_ctrl.sv
// Simulation-termination sequencer: ebreak -> drain memory writes -> one-cycle exit report,
// plus a commit watchdog that forces a bad-trap exit when retirement stalls.
module halt_ctrl #(
   parameter int unsigned WDT_CYCLES   = 65536,
   parameter int unsigned DRAIN_MAX    = 256,
   parameter logic [63:0] TIMEOUT_CODE = 64'hDEAD
) (
   input logic        clock,
   input logic        reset,
   halt_ctrl_if.slave bus
);

   localparam int unsigned WdtW   = $clog2(WDT_CYCLES) + 1;
   localparam int unsigned DrainW = $clog2(DRAIN_MAX) + 1;
   localparam logic [WdtW-1:0]   WdtLast   = WdtW'(WDT_CYCLES - 1);
   localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_MAX - 1);

   typedef enum logic [1:0] {StRun, StDrain, StReport, StHalted} state_e;

   state_e              state_q, state_d;
   logic [WdtW-1:0]     wdt_q, wdt_d;
   logic [DrainW-1:0]   drain_q, drain_d;
   logic [63:0]         last_pc_q, last_pc_d;
   logic [63:0]         exit_pc_q, exit_pc_d;
   logic [31:0]         exit_inst_q, exit_inst_d;
   logic [63:0]         exit_code_q, exit_code_d;
   logic                timeout_q, timeout_d;

   always_comb begin
      state_d     = state_q;
      wdt_d       = wdt_q;
      drain_d     = drain_q;
      last_pc_d   = last_pc_q;
      exit_pc_d   = exit_pc_q;
      exit_inst_d = exit_inst_q;
      exit_code_d = exit_code_q;
      timeout_d   = timeout_q;

      unique case (state_q)
         StRun: begin
            drain_d = '0;
            if (bus.commit_valid) begin
               wdt_d     = '0;
               last_pc_d = bus.commit_pc;
            end else if (wdt_q != '1) begin
               wdt_d = wdt_q + 1'b1;
            end
            // A commit clears the watchdog, so an ebreak always beats a same-cycle expiry.
            if (bus.commit_valid && bus.commit_is_ebreak) begin
               exit_pc_d   = bus.commit_pc;
               exit_inst_d = bus.commit_inst;
               exit_code_d = bus.a0_value;
               state_d     = StDrain;
            end else if (!bus.commit_valid && wdt_q >= WdtLast) begin
               exit_pc_d   = last_pc_q;
               exit_inst_d = '0;
               exit_code_d = TIMEOUT_CODE;
               timeout_d   = 1'b1;
               state_d     = StReport;
            end
         end
         StDrain: begin
            drain_d = drain_q + 1'b1;
            if (!bus.mem_busy) begin
               state_d = StReport;
            end else if (drain_q >= DrainLast) begin
               exit_code_d = TIMEOUT_CODE;
               timeout_d   = 1'b1;
               state_d     = StReport;
            end
         end
         StReport: state_d = StHalted;
         StHalted: state_d = StHalted;
         default:  state_d = StRun;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= StRun;
         wdt_q       <= '0;
         drain_q     <= '0;
         last_pc_q   <= '0;
         exit_pc_q   <= '0;
         exit_inst_q <= '0;
         exit_code_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wdt_q       <= wdt_d;
         drain_q     <= drain_d;
         last_pc_q   <= last_pc_d;
         exit_pc_q   <= exit_pc_d;
         exit_inst_q <= exit_inst_d;
         exit_code_q <= exit_code_d;
         timeout_q   <= timeout_d;
      end
   end

   // Decoded from the registered state, so halt_req rises the cycle after the ebreak commit.
   assign bus.halt_req  = (state_q != StRun);
   assign bus.exit      = (state_q == StReport);
   assign bus.exit_pc   = exit_pc_q;
   assign bus.exit_inst = exit_inst_q;
   assign bus.exit_code = exit_code_q;
   assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_halt_ctrl.sv
// Directed self-checking bench for halt_ctrl (WDT_CYCLES=16, DRAIN_MAX=8).
module tb_halt_ctrl;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;

   halt_ctrl_if bus ();

   halt_ctrl #(
      .WDT_CYCLES  (16),
      .DRAIN_MAX   (8),
      .TIMEOUT_CODE(64'hDEAD)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      bus.commit_valid     = 1'b0;
      bus.commit_is_ebreak = 1'b0;
      bus.commit_pc        = '0;
      bus.commit_inst      = '0;
      bus.a0_value         = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      bus.mem_busy = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic drive_commit(input logic [63:0] pc, input logic [31:0] inst,
                               input logic [63:0] a0, input logic is_ebreak);
      bus.commit_valid     = 1'b1;
      bus.commit_is_ebreak = is_ebreak;
      bus.commit_pc        = pc;
      bus.commit_inst      = inst;
      bus.a0_value         = a0;
   endtask

   // Runs edges after a presented commit until exit; mem_busy is high at edges 1..busy_until.
   task automatic wait_exit(input int busy_until, input bit noise, output int lat,
                            output logic h1);
      lat = -1;
      h1  = 1'bx;
      bus.mem_busy = (busy_until >= 1);
      for (int n = 1; n <= 40; n++) begin
         step();
         if (n == 1) h1 = bus.halt_req;
         if (noise) drive_commit(64'h9000_0000 + 64'(n), 32'hFFFF_FFFF, 64'hBAD, 1'b1);
         else idle_inputs();
         bus.mem_busy = (n + 1 <= busy_until);
         if (bus.exit === 1'b1) begin
            lat = n;
            break;
         end
      end
      idle_inputs();
      bus.mem_busy = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      bus.mem_busy = 1'b0;
      step();
      checks++;
      if ({bus.halt_req, bus.exit, bus.timeout} !== 3'b000) begin
         $display("FAIL reset_flags: got %b want 000", {bus.halt_req, bus.exit, bus.timeout});
         errors++;
      end
      checks++;
      if ({bus.exit_pc, bus.exit_inst, bus.exit_code} !== 160'd0) begin
         $display("FAIL reset_record: got %h/%h/%h want 0", bus.exit_pc, bus.exit_inst,
                  bus.exit_code);
         errors++;
      end
   endtask

   task automatic test_good_trap();
      int   lat;
      logic h1;
      int   extra;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive_commit(64'h8000_0000 + 64'(4 * i), 32'h0000_0013, 64'(i), 1'b0);
         step();
      end
      drive_commit(64'h8000_0010, 32'h0010_0073, 64'h0, 1'b1);
      wait_exit(0, 1'b0, lat, h1);
      checks++;
      if (h1 !== 1'b1) begin
         $display("FAIL good_halt_req: got %b want 1", h1);
         errors++;
      end
      checks++;
      if (lat != 2) begin
         $display("FAIL good_latency: got %0d want 2", lat);
         errors++;
      end
      checks++;
      if (bus.exit_pc !== 64'h8000_0010 || bus.exit_inst !== 32'h0010_0073) begin
         $display("FAIL good_pc_inst: got %h/%h want 80000010/00100073", bus.exit_pc,
                  bus.exit_inst);
         errors++;
      end
      checks++;
      if (bus.exit_code !== 64'h0 || bus.timeout !== 1'b0) begin
         $display("FAIL good_code: got %h/%b want 0/0", bus.exit_code, bus.timeout);
         errors++;
      end
      extra = 0;
      for (int i = 0; i < 8; i++) begin
         drive_commit(64'h1234, 32'h0010_0073, 64'h1, 1'b1);
         step();
         if (bus.exit === 1'b1) extra++;
      end
      idle_inputs();
      checks++;
      if (extra != 0 || bus.halt_req !== 1'b1) begin
         $display("FAIL good_no_repeat: got pulses=%0d halt=%b want 0/1", extra, bus.halt_req);
         errors++;
      end
   endtask

   task automatic test_drain();
      int   lat;
      logic h1;
      do_reset();
      drive_commit(64'h8000_0020, 32'h0010_0073, 64'h5, 1'b1);
      wait_exit(5, 1'b1, lat, h1);
      checks++;
      if (lat != 6) begin
         $display("FAIL drain_latency: got %0d want 6", lat);
         errors++;
      end
      checks++;
      if (bus.exit_pc !== 64'h8000_0020 || bus.exit_inst !== 32'h0010_0073) begin
         $display("FAIL drain_pc_inst: got %h/%h want 80000020/00100073", bus.exit_pc,
                  bus.exit_inst);
         errors++;
      end
      checks++;
      if (bus.exit_code !== 64'h5 || bus.timeout !== 1'b0) begin
         $display("FAIL drain_code: got %h/%b want 5/0", bus.exit_code, bus.timeout);
         errors++;
      end
   endtask

   task automatic test_drain_timeout();
      int   lat;
      logic h1;
      do_reset();
      drive_commit(64'h8000_0030, 32'h0010_0073, 64'h7, 1'b1);
      wait_exit(1000, 1'b1, lat, h1);
      checks++;
      if (lat != 9) begin
         $display("FAIL dto_latency: got %0d want 9", lat);
         errors++;
      end
      checks++;
      if (bus.exit_code !== 64'hDEAD || bus.timeout !== 1'b1) begin
         $display("FAIL dto_code: got %h/%b want dead/1", bus.exit_code, bus.timeout);
         errors++;
      end
      checks++;
      if (bus.exit_pc !== 64'h8000_0030 || bus.exit_inst !== 32'h0010_0073) begin
         $display("FAIL dto_pc_inst: got %h/%h want 80000030/00100073", bus.exit_pc,
                  bus.exit_inst);
         errors++;
      end
   endtask

   task automatic test_watchdog();
      int   lat;
      logic h1;
      do_reset();
      drive_commit(64'h8000_0004, 32'h0000_0013, 64'h9, 1'b0);
      wait_exit(0, 1'b0, lat, h1);
      checks++;
      if (lat != 17 || h1 !== 1'b0) begin
         $display("FAIL wdt_latency: got %0d/halt=%b want 17/0", lat, h1);
         errors++;
      end
      checks++;
      if (bus.exit_pc !== 64'h8000_0004 || bus.exit_inst !== 32'h0) begin
         $display("FAIL wdt_pc_inst: got %h/%h want 80000004/0", bus.exit_pc, bus.exit_inst);
         errors++;
      end
      checks++;
      if (bus.exit_code !== 64'hDEAD || bus.timeout !== 1'b1) begin
         $display("FAIL wdt_code: got %h/%b want dead/1", bus.exit_code, bus.timeout);
         errors++;
      end
   endtask

   task automatic test_simultaneous();
      int   lat;
      logic h1;
      do_reset();
      drive_commit(64'h8000_0008, 32'h0000_0013, 64'h0, 1'b0);
      step();
      idle_inputs();
      for (int i = 0; i < 15; i++) step();
      checks++;
      if (bus.exit !== 1'b0 || bus.halt_req !== 1'b0) begin
         $display("FAIL sim_early: got exit=%b halt=%b want 0/0", bus.exit, bus.halt_req);
         errors++;
      end
      drive_commit(64'h8000_000C, 32'h0010_0073, 64'h77, 1'b1);
      wait_exit(0, 1'b0, lat, h1);
      checks++;
      if (lat != 2 || bus.timeout !== 1'b0) begin
         $display("FAIL sim_path: got lat=%0d timeout=%b want 2/0", lat, bus.timeout);
         errors++;
      end
      checks++;
      if (bus.exit_pc !== 64'h8000_000C || bus.exit_code !== 64'h77) begin
         $display("FAIL sim_record: got %h/%h want 8000000c/77", bus.exit_pc, bus.exit_code);
         errors++;
      end
   endtask

   task automatic test_reset_mid();
      int   lat;
      logic h1;
      do_reset();
      drive_commit(64'h8000_0040, 32'h0010_0073, 64'h9, 1'b1);
      bus.mem_busy = 1'b1;
      step();
      idle_inputs();
      step();
      step();
      checks++;
      if (bus.halt_req !== 1'b1 || bus.exit_pc !== 64'h8000_0040) begin
         $display("FAIL rst_pre: got halt=%b pc=%h want 1/80000040", bus.halt_req, bus.exit_pc);
         errors++;
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({bus.halt_req, bus.exit, bus.timeout} !== 3'b000 ||
          {bus.exit_pc, bus.exit_inst, bus.exit_code} !== 160'd0) begin
         $display("FAIL rst_async: got halt=%b pc=%h code=%h want 0/0/0", bus.halt_req,
                  bus.exit_pc, bus.exit_code);
         errors++;
      end
      bus.mem_busy = 1'b0;
      step();
      reset = 1'b0;
      drive_commit(64'h8000_0050, 32'h0010_0073, 64'h3, 1'b1);
      wait_exit(0, 1'b0, lat, h1);
      checks++;
      if (lat != 2 || bus.exit_pc !== 64'h8000_0050 || bus.exit_code !== 64'h3) begin
         $display("FAIL rst_fresh: got lat=%0d pc=%h code=%h want 2/80000050/3", lat,
                  bus.exit_pc, bus.exit_code);
         errors++;
      end
   endtask

   initial begin
      test_reset();
      test_good_trap();
      test_drain();
      test_drain_timeout();
      test_watchdog();
      test_simultaneous();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL sim_timeout: got no finish want finish");
      $fatal(1, "bench time limit");
   end

endmodule
